// File: rtl/keccak_msg_feeder_if.sv
// Signal bundle between the hashing control, the message feeder and the Keccak core.
// The master view is the feeder; the slave view is its environment.
interface keccak_msg_feeder_if #(
    parameter int D     = 512,
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] msg_len;
    logic             busy;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             core_reset;
    logic [63:0]      core_in;
    logic             core_in_ready;
    logic             core_is_last;
    logic [2:0]       core_byte_num;
    logic             core_buffer_full;
    logic [D-1:0]     core_out;
    logic             core_out_ready;
    logic [D-1:0]     digest;
    logic             digest_valid;
    logic             done;

    modport master (
        input  start, msg_len, byte_in, byte_valid, core_buffer_full, core_out, core_out_ready,
        output busy, byte_ready, core_reset, core_in, core_in_ready, core_is_last,
               core_byte_num, digest, digest_valid, done
    );

    modport slave (
        output start, msg_len, byte_in, byte_valid, core_buffer_full, core_out, core_out_ready,
        input  busy, byte_ready, core_reset, core_in, core_in_ready, core_is_last,
               core_byte_num, digest, digest_valid, done
    );
endinterface

// File: rtl/keccak_msg_feeder.sv
// Packs a byte stream big-endian into 64-bit words for the Keccak core, re-arms the
// core per message and captures the digest once the core reports it.
module keccak_msg_feeder #(
    parameter int D     = 512,
    parameter int LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    keccak_msg_feeder_if.master  bus
);

    typedef enum logic [2:0] {IDLE, CRST, GATHER, SEND, WAIT_OUT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [63:0]      r_word;
    logic [3:0]       r_cnt;
    logic [LEN_W-1:0] r_rem;
    logic             r_last;
    logic [2:0]       r_bnum;
    logic             r_pend;
    logic             r_busy;
    logic [D-1:0]     r_digest;
    logic             r_dvalid;
    logic             r_done;

    logic             w_byte_ready;
    logic             w_xfer;
    logic [3:0]       w_cnt_inc;
    logic [LEN_W-1:0] w_rem_dec;
    logic [63:0]      w_word_ins;

    assign w_byte_ready = (r_state == GATHER) && (r_cnt < 4'd8) && (r_rem != '0);
    assign w_xfer       = bus.byte_valid && w_byte_ready;
    assign w_cnt_inc    = r_cnt + 4'd1;
    assign w_rem_dec    = r_rem - LEN_W'(1);
    // Byte k of the word lands in bits [63-8k -: 8]; lower bytes stay zero until filled.
    assign w_word_ins   = r_word | ({bus.byte_in, 56'd0} >> {r_cnt[2:0], 3'b000});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (bus.start) w_state_nxt = CRST;
            CRST:     w_state_nxt = (r_rem == '0) ? SEND : GATHER;
            GATHER:   if (w_xfer && ((w_cnt_inc == 4'd8) || (w_rem_dec == '0))) w_state_nxt = SEND;
            SEND: begin
                if (!bus.core_buffer_full) begin
                    if (r_last)       w_state_nxt = WAIT_OUT;
                    else if (!r_pend) w_state_nxt = GATHER;
                end
            end
            WAIT_OUT: if (bus.core_out_ready) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word   <= '0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_last   <= 1'b0;
            r_bnum   <= '0;
            r_pend   <= 1'b0;
            r_busy   <= 1'b0;
            r_digest <= '0;
            r_dvalid <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_rem    <= bus.msg_len;
                        r_word   <= '0;
                        r_cnt    <= '0;
                        r_last   <= 1'b0;
                        r_bnum   <= '0;
                        r_pend   <= 1'b0;
                        r_dvalid <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                CRST: begin
                    if (r_rem == '0) begin
                        r_word <= '0;
                        r_last <= 1'b1;
                        r_bnum <= '0;
                    end
                end
                GATHER: begin
                    if (w_xfer) begin
                        r_word <= w_word_ins;
                        r_cnt  <= w_cnt_inc;
                        r_rem  <= w_rem_dec;
                        // A full final word still needs an empty is_last word behind it.
                        if (w_cnt_inc == 4'd8) begin
                            r_last <= 1'b0;
                            r_bnum <= '0;
                            r_pend <= (w_rem_dec == '0);
                        end else if (w_rem_dec == '0) begin
                            r_last <= 1'b1;
                            r_bnum <= w_cnt_inc[2:0];
                        end
                    end
                end
                SEND: begin
                    if (!bus.core_buffer_full && !r_last) begin
                        r_word <= '0;
                        if (r_pend) begin
                            r_last <= 1'b1;
                            r_bnum <= '0;
                            r_pend <= 1'b0;
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                end
                WAIT_OUT: begin
                    if (bus.core_out_ready) begin
                        r_digest <= bus.core_out;
                        r_dvalid <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The system reset already clears the core, so the re-arm pulse is suppressed then.
    assign bus.core_reset    = (r_state == CRST) && !reset;
    assign bus.byte_ready    = w_byte_ready;
    assign bus.core_in_ready = (r_state == SEND);
    assign bus.core_in       = (r_state == SEND) ? r_word : 64'd0;
    assign bus.core_is_last  = (r_state == SEND) && r_last;
    assign bus.core_byte_num = (r_state == SEND) ? r_bnum : 3'd0;
    assign bus.busy          = r_busy;
    assign bus.digest        = r_digest;
    assign bus.digest_valid  = r_dvalid;
    assign bus.done          = r_done;

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Bench for keccak_msg_feeder: a behavioural core stand-in plus a word scoreboard
// and a table of messages, followed by hand-written reset and busy-start sequences.
module tb_keccak_msg_feeder;

    localparam int D     = 512;
    localparam int LEN_W = 16;
    localparam logic [D-1:0] SHA_ABC = 512'hb751850b1a57168a5693cd924b6b096e08f621827444f70d884f5d0240d2712e10e116e9192af3c91a7ec57647e3934057340b4cf408d5a56592f8274eec53f0;
    localparam logic [D-1:0] SHA_EMPTY = 512'ha69f73cca23a9ac5c8b567dc185a756e97c982164fe25859e0d1dcc1475c80a615b2123af1f5f94c11e3e9402c3ac558f500199d95b6d3e301758586281dcd26;
    localparam logic [63:0] ABC_W = 64'h6162630000000000;

    typedef struct {
        logic [63:0] w;
        logic        last;
        logic [2:0]  bn;
    } word_t;

    typedef struct {
        int          len;
        int          pat;
        int          stall;
        bit          poke;
        logic [63:0] w0;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    keccak_msg_feeder_if #(.D(D), .LEN_W(LEN_W)) bus ();
    keccak_msg_feeder #(.D(D), .LEN_W(LEN_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int          checks = 0;
    int          failures = 0;
    word_t       sbq[$];
    logic [7:0]  msg[0:63];
    int          stall_req = 0;
    int          n_crst = 0, n_bready = 0, n_stall = 0, n_pop = 0;
    bit          holding = 0;
    word_t       held;
    logic [63:0] first_w;

    function automatic logic [D-1:0] mix(input logic [D-1:0] a, input logic [63:0] w,
                                         input logic l, input logic [2:0] b);
        return {a[D-65:0], a[D-1 -: 64] ^ w ^ {60'd0, l, b}};
    endfunction

    // Core stand-in: folds every accepted word into a digest, reports it 3 cycles after
    // the last word, holds it until re-armed, and can refuse the first word of a message.
    logic [D-1:0] m_acc, m_fin, m_out;
    logic         m_rdy;
    int           m_nw, m_dly, stall_left;

    always @(posedge clk) begin
        if (reset || bus.core_reset) begin
            m_acc      <= '0;
            m_fin      <= '0;
            m_out      <= '0;
            m_rdy      <= 1'b0;
            m_nw       <= 0;
            m_dly      <= 0;
            stall_left <= reset ? 0 : stall_req;
        end else begin
            if (bus.core_in_ready && stall_left != 0) stall_left <= stall_left - 1;
            if (bus.core_in_ready && !bus.core_buffer_full) begin
                m_acc <= mix(m_acc, bus.core_in, bus.core_is_last, bus.core_byte_num);
                m_nw  <= m_nw + 1;
                if (bus.core_is_last) begin
                    m_dly <= 3;
                    if (m_nw == 0 && bus.core_in == ABC_W && bus.core_byte_num == 3'd3)
                        m_fin <= SHA_ABC;
                    else if (m_nw == 0 && bus.core_in == 64'd0 && bus.core_byte_num == 3'd0)
                        m_fin <= SHA_EMPTY;
                    else
                        m_fin <= mix(m_acc, bus.core_in, bus.core_is_last, bus.core_byte_num);
                end
            end
            if (m_dly != 0) begin
                m_dly <= m_dly - 1;
                if (m_dly == 1) begin
                    m_rdy <= 1'b1;
                    m_out <= m_fin;
                end
            end
        end
    end

    assign bus.core_buffer_full = (stall_left != 0);
    assign bus.core_out         = m_out;
    assign bus.core_out_ready   = m_rdy;

    task automatic chk(input string nm, input logic [D-1:0] act, input logic [D-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fill_msg(input int len, input int pat);
        for (int i = 0; i < 64; i++) begin
            if (pat == 0)      msg[i] = (i == 0) ? 8'h61 : (i == 1) ? 8'h62 : (i == 2) ? 8'h63 : 8'h00;
            else if (pat == 1) msg[i] = 8'(i);
            else               msg[i] = 8'(i * 37 + 5);
        end
        if (len < 0) $display("negative length");
    endtask

    // Expected word sequence and digest, derived from the message bytes alone.
    task automatic build_exp(input int len, input int pat, output logic [D-1:0] dig);
        word_t e;
        logic [63:0] w;
        int k;
        logic [D-1:0] acc;
        w = '0; k = 0; acc = '0;
        for (int i = 0; i < len; i++) begin
            w[63-8*k -: 8] = msg[i];
            k++;
            if (k == 8) begin
                e = '{w, 1'b0, 3'd0};
                sbq.push_back(e);
                acc = mix(acc, e.w, e.last, e.bn);
                w = '0; k = 0;
            end
        end
        e = '{w, 1'b1, 3'(k)};
        sbq.push_back(e);
        acc = mix(acc, e.w, e.last, e.bn);
        if (len == 3 && pat == 0) dig = SHA_ABC;
        else if (len == 0)        dig = SHA_EMPTY;
        else                      dig = acc;
    endtask

    task automatic mon_cycle();
        word_t cur, e;
        cur = '{bus.core_in, bus.core_is_last, bus.core_byte_num};
        if (bus.core_reset) n_crst++;
        if (bus.byte_ready) n_bready++;
        if (!bus.core_in_ready) begin
            chk("idle_last_bn", {cur.last, cur.bn}, 0);
        end else if (bus.core_buffer_full) begin
            n_stall++;
            if (!holding) begin
                held = cur;
                holding = 1;
            end else begin
                chk("stall_stable", {cur.w, cur.last, cur.bn}, {held.w, held.last, held.bn});
            end
        end else begin
            if (holding) chk("stall_stable_accept", {cur.w, cur.last, cur.bn}, {held.w, held.last, held.bn});
            holding = 0;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_word actual=%0h required=none", cur.w);
            end else begin
                e = sbq.pop_front();
                chk("word", cur.w, e.w);
                chk("is_last", cur.last, e.last);
                chk("byte_num", cur.bn, e.bn);
                if (n_pop == 0) first_w = cur.w;
                n_pop++;
            end
        end
    endtask

    task automatic run_msg(input vec_t v, output logic [D-1:0] dig);
        logic [D-1:0] exp_d;
        int i, cyc, crst0, br0;
        bit ok;
        fill_msg(v.len, v.pat);
        sbq.delete();
        build_exp(v.len, v.pat, exp_d);
        stall_req = v.stall;
        n_stall = 0; n_pop = 0; holding = 0; first_w = 64'hdeadbeefdeadbeef;
        crst0 = n_crst; br0 = n_bready;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.msg_len = LEN_W'(v.len);
        bus.byte_valid = 1'b0;
        i = 0; cyc = 0; ok = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            mon_cycle();
            if (cyc == 1) begin
                chk("core_reset_pulse", bus.core_reset, 1);
                chk("busy_set", bus.busy, 1);
                chk("dvalid_cleared", bus.digest_valid, 0);
            end
            if (cyc == 2) chk("byte_ready_latency", bus.byte_ready, (v.len > 0));
            if (bus.byte_valid && bus.byte_ready) i++;
            if (bus.done) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            bus.start = v.poke && (cyc == 6);
            bus.msg_len = LEN_W'((v.poke && cyc == 6) ? 2 : v.len);
            bus.byte_valid = (i < v.len) && ($urandom_range(0, 3) != 0);
            bus.byte_in = msg[i];
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL timeout_done actual=no_done required=done len=%0d", v.len);
        end
        chk("digest", bus.digest, exp_d);
        chk("digest_valid", bus.digest_valid, 1);
        chk("busy_clear", bus.busy, 0);
        chk("crst_count", n_crst - crst0, 1);
        chk("bytes_moved", i, v.len);
        chk("sb_drained", sbq.size(), 0);
        chk("first_word", first_w, v.w0);
        if (v.len == 0) chk("no_byte_ready", n_bready - br0, 0);
        if (v.stall > 0) chk("stall_cycles", n_stall, v.stall);
        dig = bus.digest;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.byte_valid = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("digest_hold", bus.digest, exp_d);
        chk("dvalid_hold", bus.digest_valid, 1);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"}, bus.busy, 0);
        chk({pfx, "_byte_ready"}, bus.byte_ready, 0);
        chk({pfx, "_core_reset"}, bus.core_reset, 0);
        chk({pfx, "_core_in"}, bus.core_in, 0);
        chk({pfx, "_in_ready"}, bus.core_in_ready, 0);
        chk({pfx, "_is_last"}, bus.core_is_last, 0);
        chk({pfx, "_byte_num"}, bus.core_byte_num, 0);
        chk({pfx, "_digest"}, bus.digest, 0);
        chk({pfx, "_dvalid"}, bus.digest_valid, 0);
        chk({pfx, "_done"}, bus.done, 0);
    endtask

    vec_t         vt[8];
    logic [D-1:0] digs[8];
    logic [D-1:0] d_tmp;

    initial begin
        vt[0] = '{3,  0, 0, 1'b0, 64'h6162630000000000};
        vt[1] = '{8,  1, 0, 1'b0, 64'h0001020304050607};
        vt[2] = '{0,  1, 0, 1'b0, 64'h0000000000000000};
        vt[3] = '{11, 2, 5, 1'b0, 64'h052a4f7499bee308};
        vt[4] = '{16, 1, 0, 1'b0, 64'h0001020304050607};
        vt[5] = '{5,  2, 0, 1'b1, 64'h052a4f7499000000};
        vt[6] = '{5,  2, 0, 1'b0, 64'h052a4f7499000000};
        vt[7] = '{1,  2, 3, 1'b0, 64'h0500000000000000};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.msg_len = '0;
        bus.byte_in = '0;
        bus.byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_zero("rst");

        for (int r = 0; r < 8; r++) run_msg(vt[r], digs[r]);
        chk("poke_same_digest", digs[5], digs[6]);

        // Reset part-way through a 20-byte message, after 4 bytes have gone in.
        fill_msg(20, 1);
        stall_req = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.msg_len = LEN_W'(20);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            bus.byte_in = msg[k];
            bus.byte_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b0;
        @(negedge clk);
        chk("busy_mid_gather", bus.busy, 1);
        chk("byte_ready_mid_gather", bus.byte_ready, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_zero("midrst");
        sbq.delete();
        run_msg(vt[0], d_tmp);
        chk("post_reset_abc", d_tmp, SHA_ABC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
